// File: rtl/core_msg_receiver.sv
// Per-core receive stage: decodes scheduler beats, loads r0 init words and instructions, then launches execution.
// Optional watchdog on EXEC is enabled by defining RCV_EXEC_TIMEOUT_EN.
module core_msg_receiver #(
  parameter int CORE_ID      = 0,
  parameter int INSTR_SIZE   = 16,
  parameter int IMEM_DEPTH   = 256,
  parameter int R0_DEPTH     = 8,
  parameter int EXEC_TIMEOUT = 1024,
  localparam int IAW = $clog2(IMEM_DEPTH),
  localparam int RAW = $clog2(R0_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INSTR_SIZE-1:0] mess_to_core,
  input  logic                  core_mask_loading,
  input  logic                  r0_mask_loading,
  input  logic                  r0_loading,
  input  logic                  instr_loading,
  input  logic                  exec_done,
  output logic                  core_reading,
  output logic                  core_ready,
  output logic                  r0_we,
  output logic [RAW-1:0]        r0_addr,
  output logic [INSTR_SIZE-1:0] r0_wdata,
  output logic                  imem_we,
  output logic [IAW-1:0]        imem_addr,
  output logic [INSTR_SIZE-1:0] imem_wdata,
  output logic                  start_exec,
  output logic [IAW:0]          instr_count,
  output logic                  proto_err
);

  typedef enum logic [2:0] {IDLE, SEL, LOAD_R0, LOAD_I, EXEC} state_t;

  state_t       state;
  logic         selected;
  logic         r0_sel;
  logic [RAW:0] r0_cnt;

  logic mask_b, r0m_b, r0_b, ins_b, beat, multi, core_bit;

  always_comb begin
    mask_b   = core_mask_loading;
    r0m_b    = r0_mask_loading & ~core_mask_loading;
    r0_b     = r0_loading & ~r0_mask_loading & ~core_mask_loading;
    ins_b    = instr_loading & ~r0_loading & ~r0_mask_loading & ~core_mask_loading;
    beat     = core_mask_loading | r0_mask_loading | r0_loading | instr_loading;
    multi    = (core_mask_loading & (r0_mask_loading | r0_loading | instr_loading)) |
               (r0_mask_loading & (r0_loading | instr_loading)) |
               (r0_loading & instr_loading);
    core_bit = mess_to_core[CORE_ID];
  end

`ifdef RCV_EXEC_TIMEOUT_EN
  localparam int TW = $clog2(EXEC_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(EXEC_TIMEOUT - 1);
  logic [TW-1:0] to_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      selected     <= 1'b0;
      r0_sel       <= 1'b0;
      r0_cnt       <= '0;
      core_reading <= 1'b1;
      core_ready   <= 1'b1;
      r0_we        <= 1'b0;
      r0_addr      <= '0;
      r0_wdata     <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      start_exec   <= 1'b0;
      instr_count  <= '0;
      proto_err    <= 1'b0;
`ifdef RCV_EXEC_TIMEOUT_EN
      to_cnt       <= '0;
`endif
    end else begin
      r0_we      <= 1'b0;
      imem_we    <= 1'b0;
      start_exec <= 1'b0;
      if (multi) proto_err <= 1'b1;

      if (mask_b && state != EXEC) begin
        // Mask beat outside EXEC always restarts selection, abandoning any partial task.
        selected <= core_bit;
        if (core_bit) begin
          state       <= SEL;
          r0_cnt      <= '0;
          instr_count <= '0;
        end else begin
          state <= IDLE;
        end
      end else begin
        case (state)
          IDLE: ;
          SEL: begin
            if (r0m_b) begin
              r0_sel <= core_bit;
              state  <= LOAD_R0;
            end else if (r0_b || ins_b) begin
              proto_err <= 1'b1;
            end
          end
          LOAD_R0, LOAD_I: begin
            // Depths are powers of two, so the counter MSB marks "full".
            if (ins_b && selected) begin
              state <= LOAD_I;
              if (!instr_count[IAW]) begin
                imem_we     <= 1'b1;
                imem_addr   <= instr_count[IAW-1:0];
                imem_wdata  <= mess_to_core;
                instr_count <= instr_count + 1'b1;
              end else begin
                proto_err <= 1'b1;
              end
            end else if (state == LOAD_R0 && r0_b) begin
              if (r0_sel && !r0_cnt[RAW]) begin
                r0_we    <= 1'b1;
                r0_addr  <= r0_cnt[RAW-1:0];
                r0_wdata <= mess_to_core;
                r0_cnt   <= r0_cnt + 1'b1;
              end
            end else if (state == LOAD_I && !beat && instr_count != '0) begin
              start_exec   <= 1'b1;
              core_ready   <= 1'b0;
              core_reading <= 1'b0;
              state        <= EXEC;
`ifdef RCV_EXEC_TIMEOUT_EN
              to_cnt       <= '0;
`endif
            end
          end
          EXEC: begin
            if (mask_b) proto_err <= 1'b1;
            if (exec_done) begin
              state        <= IDLE;
              core_ready   <= 1'b1;
              core_reading <= 1'b1;
            end
`ifdef RCV_EXEC_TIMEOUT_EN
            else if (to_cnt == TO_LAST) begin
              state        <= IDLE;
              core_ready   <= 1'b1;
              core_reading <= 1'b1;
              proto_err    <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_core_msg_receiver.sv
// Directed bench for core_msg_receiver with CORE_ID=3 and EXEC_TIMEOUT=16.
module tb_core_msg_receiver;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] msg;
  logic        cm, rm, r0l, il, exec_done;
  logic        core_reading, core_ready, r0_we, imem_we, start_exec, proto_err;
  logic [2:0]  r0_addr;
  logic [15:0] r0_wdata, imem_wdata;
  logic [7:0]  imem_addr;
  logic [8:0]  instr_count;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [3:0] N = 4'b0000, M = 4'b1000, RM = 4'b0100, R = 4'b0010, I = 4'b0001;

  core_msg_receiver #(.CORE_ID(3), .INSTR_SIZE(16), .IMEM_DEPTH(256), .R0_DEPTH(8), .EXEC_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .mess_to_core(msg),
    .core_mask_loading(cm), .r0_mask_loading(rm), .r0_loading(r0l), .instr_loading(il),
    .exec_done(exec_done), .core_reading(core_reading), .core_ready(core_ready),
    .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .start_exec(start_exec), .instr_count(instr_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of strobes/data; returns 1 time unit after the edge.
  task automatic drive(input logic [3:0] s, input logic [15:0] d);
    {cm, rm, r0l, il} = s;
    msg = d;
    @(posedge clk);
    #1;
    {cm, rm, r0l, il} = N;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(N, 16'h0);
    drive(N, 16'h0);
    reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".reading"}, 32'(core_reading), 32'd1);
    chk({tag, ".ready"}, 32'(core_ready), 32'd1);
    chk({tag, ".r0_we"}, 32'(r0_we), 32'd0);
    chk({tag, ".imem_we"}, 32'(imem_we), 32'd0);
    chk({tag, ".start"}, 32'(start_exec), 32'd0);
    chk({tag, ".icount"}, 32'(instr_count), 32'd0);
    chk({tag, ".perr"}, 32'(proto_err), 32'd0);
  endtask

  initial begin
    logic [15:0] w;
    reset = 1'b0; exec_done = 1'b0; msg = '0; {cm, rm, r0l, il} = N;
    do_reset();
    chk_reset_vals("rst");

    // Selected task: 2 r0 words, 4 instructions, then launch.
    drive(M, 16'h0008);
    drive(RM, 16'h0008);
    drive(R, 16'h1111);
    chk("t1.r0we0", 32'(r0_we), 32'd1);
    chk("t1.r0a0", 32'(r0_addr), 32'd0);
    chk("t1.r0d0", 32'(r0_wdata), 32'h1111);
    drive(R, 16'h2222);
    chk("t1.r0a1", 32'({r0_we, r0_addr}), 32'({1'b1, 3'd1}));
    chk("t1.r0d1", 32'(r0_wdata), 32'h2222);
    for (int i = 0; i < 4; i++) begin
      w = 16'hA001 + 16'(i);
      drive(I, w);
      chk("t1.iwe", 32'({imem_we, r0_we}), 32'b10);
      chk("t1.iaddr", 32'(imem_addr), 32'(i));
      chk("t1.idata", 32'(imem_wdata), 32'(w));
      chk("t1.icnt", 32'(instr_count), 32'(i + 1));
    end
    drive(N, 16'h0);
    chk("t1.start", 32'(start_exec), 32'd1);
    chk("t1.ready", 32'({core_ready, core_reading}), 32'd0);
    chk("t1.iwe_off", 32'(imem_we), 32'd0);
    drive(N, 16'h0);
    chk("t1.start_pulse", 32'(start_exec), 32'd0);

    // EXEC: mask beat is an error and does not leave EXEC.
    drive(M, 16'h0008);
    chk("ex.perr", 32'(proto_err), 32'd1);
    chk("ex.stay", 32'(core_ready), 32'd0);
    exec_done = 1'b1;
    drive(N, 16'h0);
    exec_done = 1'b0;
    chk("ex.done", 32'({core_ready, core_reading}), 32'b11);

    // Unselected core ignores loads.
    do_reset();
    drive(M, 16'h0004);
    drive(RM, 16'h0008);
    drive(R, 16'h5555);
    chk("t2.r0we", 32'(r0_we), 32'd0);
    drive(I, 16'h6666);
    chk("t2.iwe", 32'(imem_we), 32'd0);
    drive(N, 16'h0);
    chk("t2.start", 32'(start_exec), 32'd0);
    chk("t2.ready", 32'(core_ready), 32'd1);
    chk("t2.perr", 32'(proto_err), 32'd0);

    // r0_sel=0: r0 words dropped, instructions still load.
    drive(M, 16'h0008);
    drive(RM, 16'h0000);
    for (int i = 0; i < 13; i++) begin
      drive(R, 16'(16'h0100 + i));
      chk("t3.r0we", 32'(r0_we), 32'd0);
    end
    drive(I, 16'hB000);
    chk("t3.i0", 32'({imem_we, imem_addr}), 32'({1'b1, 8'd0}));
    drive(I, 16'hB001);
    chk("t3.i1", 32'({imem_we, imem_addr}), 32'({1'b1, 8'd1}));
    drive(N, 16'h0);
    chk("t3.start", 32'(start_exec), 32'd1);
    exec_done = 1'b1;
    drive(N, 16'h0);
    exec_done = 1'b0;
    chk("t3.perr", 32'(proto_err), 32'd0);

    // r0 overflow: 10 words, only 8 written.
    drive(M, 16'h0008);
    drive(RM, 16'h0008);
    for (int i = 0; i < 10; i++) begin
      drive(R, 16'(16'hC000 + i));
      chk("t4.r0we", 32'(r0_we), (i < 8) ? 32'd1 : 32'd0);
      if (i < 8) chk("t4.r0addr", 32'(r0_addr), 32'(i));
    end
    chk("t4.perr", 32'(proto_err), 32'd0);

    // Mask + instr together: mask wins (restart), error flagged.
    drive(M | I, 16'h0008);
    chk("t5.perr", 32'(proto_err), 32'd1);
    chk("t5.iwe", 32'(imem_we), 32'd0);
    chk("t5.icnt", 32'(instr_count), 32'd0);
    drive(RM, 16'h0008);
    drive(R, 16'h7777);
    chk("t5.restart", 32'({r0_we, r0_addr}), 32'({1'b1, 3'd0}));

    // Reset while in LOAD_I with a pending launch.
    do_reset();
    drive(M, 16'h0008);
    drive(RM, 16'h0008);
    drive(I, 16'hD001);
    chk("t6.icnt", 32'(instr_count), 32'd1);
    reset = 1'b1;
    drive(N, 16'h0);
    reset = 1'b0;
    chk_reset_vals("t6");
    drive(I, 16'hD002);
    chk("t6.idle", 32'(imem_we), 32'd0);

`ifdef RCV_EXEC_TIMEOUT_EN
    drive(M, 16'h0008);
    drive(RM, 16'h0008);
    drive(I, 16'hE001);
    drive(N, 16'h0);
    chk("to.start", 32'(start_exec), 32'd1);
    for (int i = 0; i < 15; i++) drive(N, 16'h0);
    chk("to.wait", 32'(core_ready), 32'd0);
    drive(N, 16'h0);
    chk("to.ready", 32'({core_ready, core_reading}), 32'b11);
    chk("to.perr", 32'(proto_err), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
